// File: rtl/debug_mem_dumper_pkg.sv
// Shared definitions for the data-memory debug dumper: byte width,
// parameter defaults and the dumper state encoding.
package debug_mem_dumper_pkg;

  localparam int BYTE_SIZE                     = 8;
  localparam int DEFAULT_DATA_BUS_SIZE         = 32;
  localparam int DEFAULT_DATA_MEMORY_ADDR_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/debug_mem_dumper.sv
// Walks the flat data-memory image word by word and serializes each word,
// most significant byte first, into the debug UART transmitter.
module debug_mem_dumper
  import debug_mem_dumper_pkg::*;
#(
  parameter int DATA_BUS_SIZE = DEFAULT_DATA_BUS_SIZE,
  parameter int MEM_ADDR_SIZE = DEFAULT_DATA_MEMORY_ADDR_SIZE
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [(2**MEM_ADDR_SIZE)*DATA_BUS_SIZE-1:0] i_bus_debug,
  input  logic                                      i_tx_ready,
  output logic [BYTE_SIZE-1:0]                      o_tx_data,
  output logic                                      o_tx_valid,
  output logic                                      o_busy,
  output logic                                      o_done
);

  localparam int NUM_WORDS      = 2**MEM_ADDR_SIZE;
  localparam int BYTES_PER_WORD = DATA_BUS_SIZE / BYTE_SIZE;
  localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [BYTE_CNT_W-1:0]    LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_WORD = MEM_ADDR_SIZE'(NUM_WORDS - 1);

  dump_state_t              state;
  logic [MEM_ADDR_SIZE-1:0] word_idx;
  logic [BYTE_CNT_W-1:0]    byte_cnt;
  logic [DATA_BUS_SIZE-1:0] word_reg;
  logic                     tx_fire;

  assign tx_fire   = o_tx_valid && i_tx_ready;
  assign o_tx_data = word_reg[DATA_BUS_SIZE-1 -: BYTE_SIZE];

  // Dump sequencer: latches one word per LOAD, shifts it out a byte per accepted transfer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_reg   <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= LOAD;
            word_idx <= '0;
            o_busy   <= 1'b1;
          end
        end
        LOAD: begin
          word_reg   <= i_bus_debug[int'(word_idx)*DATA_BUS_SIZE +: DATA_BUS_SIZE];
          byte_cnt   <= '0;
          state      <= SEND;
          o_tx_valid <= 1'b1;
        end
        SEND: begin
          if (tx_fire) begin
            word_reg <= word_reg << BYTE_SIZE;
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            if (byte_cnt == LAST_BYTE) begin
              o_tx_valid <= 1'b0;
              if (word_idx == LAST_WORD) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                word_idx <= word_idx + MEM_ADDR_SIZE'(1);
                state    <= LOAD;
              end
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Scoreboard bench for debug_mem_dumper with a 4-word, 32-bit image.
module tb_debug_mem_dumper;

  localparam int DBS = 32;
  localparam int MAS = 2;

  logic                     i_clk;
  logic                     i_reset;
  logic                     i_start;
  logic [(2**MAS)*DBS-1:0]  i_bus_debug;
  logic                     i_tx_ready;
  logic [7:0]               o_tx_data;
  logic                     o_tx_valid;
  logic                     o_busy;
  logic                     o_done;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;

  logic [7:0] sb [$];
  logic       stallPending = 1'b0;
  logic [7:0] heldData     = 8'h00;

  logic [7:0] expDefault [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [7:0] expSnap    [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
  bit         readyPattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  debug_mem_dumper #(
    .DATA_BUS_SIZE(DBS),
    .MEM_ADDR_SIZE(MAS)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_bus_debug(i_bus_debug),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // 100 MHz style clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: pops the scoreboard on every accepted byte and checks stall stability
  always @(negedge i_clk) begin
    if (i_reset) begin
      stallPending = 1'b0;
    end else begin
      if (stallPending && o_tx_valid) begin
        vectors++;
        if (o_tx_data !== heldData) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: got %02h, required %02h", o_tx_data, heldData);
        end
      end
      stallPending = 1'b0;
      if (o_tx_valid && i_tx_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_byte: got %02h, required no transfer", o_tx_data);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (o_tx_data !== exp) begin
            miscompares++;
            $display("[TB] FAIL tx_byte: got %02h, required %02h", o_tx_data, exp);
          end
        end
      end else if (o_tx_valid) begin
        stallPending = 1'b1;
        heldData     = o_tx_data;
      end
      if (o_done) doneCount++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic ready);
    i_start    = start;
    i_tx_ready = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic setWord(input int idx, input logic [31:0] value);
    i_bus_debug[idx*DBS +: DBS] = value;
  endtask

  task automatic pushBytes(input bit snap);
    for (int i = 0; i < 16; i++) sb.push_back(snap ? expSnap[i] : expDefault[i]);
  endtask

  // Pulses start so that the next edge (edge 0) samples it; returns in cycle 1.
  task automatic startDump();
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic waitDone(input int budget, input bit toggleReady);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (toggleReady) i_tx_ready = readyPattern[c % 4];
      @(negedge i_clk);
      if (o_done) seen = 1'b1;
      tick();
    end
    i_tx_ready = 1'b1;
    checkOutput("done_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    int doneBefore;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b1);
    setWord(0, 32'h11223344);
    setWord(1, 32'hAABBCCDD);
    setWord(2, 32'h00000000);
    setWord(3, 32'hDEADBEEF);
    repeat (3) tick();
    i_reset = 1'b0;

    // Reset state
    @(negedge i_clk);
    checkOutput("rst_valid", o_tx_valid, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_data", o_tx_data, 0);
    tick();

    // Basic dump with cycle-exact busy/done timing
    $display("[TB] basic dump");
    doneBefore = doneCount;
    pushBytes(1'b0);
    startDump();
    for (int c = 1; c <= 22; c++) begin
      @(negedge i_clk);
      checkOutput("basic_busy", o_busy, (c <= 21) ? 1 : 0);
      checkOutput("basic_done", o_done, (c == 21) ? 1 : 0);
      tick();
    end
    checkOutput("basic_sb_empty", sb.size(), 0);
    checkOutput("basic_done_count", doneCount - doneBefore, 1);

    // Backpressure
    $display("[TB] backpressure");
    pushBytes(1'b0);
    startDump();
    waitDone(200, 1'b1);
    checkOutput("bp_sb_empty", sb.size(), 0);

    // Start while busy is ignored
    $display("[TB] start while busy");
    doneBefore = doneCount;
    pushBytes(1'b0);
    startDump();
    for (int c = 1; c <= 24; c++) begin
      i_start = (c == 3 || c == 21) ? 1'b1 : 1'b0;
      @(negedge i_clk);
      checkOutput("busy_start_busy", o_busy, (c <= 21) ? 1 : 0);
      checkOutput("busy_start_done", o_done, (c == 21) ? 1 : 0);
      tick();
    end
    i_start = 1'b0;
    checkOutput("busy_start_sb_empty", sb.size(), 0);
    checkOutput("busy_start_done_count", doneCount - doneBefore, 1);

    // Reset mid-dump during word 1
    $display("[TB] reset mid-dump");
    doneBefore = doneCount;
    pushBytes(1'b0);
    startDump();
    repeat (7) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    sb.delete();
    @(negedge i_clk);
    checkOutput("mid_rst_valid", o_tx_valid, 0);
    checkOutput("mid_rst_busy", o_busy, 0);
    checkOutput("mid_rst_done", o_done, 0);
    tick();
    checkOutput("mid_rst_done_count", doneCount - doneBefore, 0);
    pushBytes(1'b0);
    startDump();
    waitDone(100, 1'b0);
    checkOutput("mid_rst_sb_empty", sb.size(), 0);

    // Snapshot: word 1 changes while its bytes are being sent
    $display("[TB] snapshot");
    pushBytes(1'b0);
    startDump();
    repeat (7) tick();
    setWord(1, 32'h55667788);
    waitDone(100, 1'b0);
    checkOutput("snap_first_sb_empty", sb.size(), 0);
    pushBytes(1'b1);
    startDump();
    waitDone(100, 1'b0);
    checkOutput("snap_second_sb_empty", sb.size(), 0);

    // Held start: back-to-back dumps with one IDLE cycle between
    $display("[TB] held start");
    doneBefore = doneCount;
    pushBytes(1'b1);
    pushBytes(1'b1);
    applyStimulus(1'b1, 1'b1);
    tick();
    for (int c = 1; c <= 24; c++) begin
      @(negedge i_clk);
      checkOutput("held_done", o_done, (c == 21) ? 1 : 0);
      if (c == 22) begin
        checkOutput("held_idle_busy", o_busy, 0);
        checkOutput("held_idle_valid", o_tx_valid, 0);
      end
      if (c == 23) begin
        checkOutput("held_load_busy", o_busy, 1);
        checkOutput("held_load_valid", o_tx_valid, 0);
      end
      if (c == 24) checkOutput("held_send_valid", o_tx_valid, 1);
      tick();
    end
    i_start = 1'b0;
    waitDone(100, 1'b0);
    repeat (2) begin
      @(negedge i_clk);
      checkOutput("held_end_busy", o_busy, 0);
      tick();
    end
    checkOutput("held_sb_empty", sb.size(), 0);
    checkOutput("held_done_count", doneCount - doneBefore, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
